ring_counter_checker: RTL and testbench
=======================================

// Module: ring_counter_checker
// PURPOSE
//   Receive-side monitor for a WIDTH-bit one-hot ring counter bus. Samples the ring each clock, checks
//   one-hot legality and rotate-left sequencing, locks after LOCK_CNT legal steps, reports the binary
//   position of the hot bit, and flags or counts sequencing errors and stalls. Sits downstream of any
//   ring counter driving phase-select or time-slot enables, as a run-time integrity checker.
// PARAMETERS
//   WIDTH      4   ring width in bits, >=2; rotation order 0001->0010->0100->1000->0001
//   LOCK_CNT   3   consecutive legal rotations needed to reach LOCKED, >=1
//   STALL_MAX  8   max consecutive hold cycles tolerated while LOCKED, >=1
//   ERR_W      8   width of saturating error counter
// PORTS
//   clk        in   1                 rising-edge clock
//   reset      in   1                 asynchronous, active-low reset
//   ring_in    in   WIDTH             ring counter bus under test
//   pos        out  $clog2(WIDTH)     index of hot bit of last sampled legal word
//   pos_valid  out  1                 pos reflects a one-hot sample
//   locked     out  1                 FSM in LOCKED
//   err_pulse  out  1                 one-cycle pulse per error detected in LOCKED
//   stall      out  1                 one-cycle pulse when hold exceeds STALL_MAX in LOCKED
//   err_count  out  ERR_W             saturating count of err_pulse + stall events
// BEHAVIOUR
//   - reset low: all regs cleared immediately; pos=0, pos_valid=0, locked=0, err_pulse=0, stall=0,
//     err_count=0, FSM=HUNT, r_cur=r_prev=0, good_cnt=0, hold_cnt=0. Release sync to clk.
//   - Pipeline: ring_in -> r_cur at edge k (r_prev <= r_cur); classification of (r_prev,r_cur) is
//     combinational; FSM and all outputs update at edge k+1. Latency ring_in -> outputs = 2 clocks.
//   - Classes: ONEHOT = popcount(r_cur)==1. STEP = ONEHOT && r_cur==rotl(r_prev,1) (MSB wraps to
//     LSB). HOLD = ONEHOT && r_cur==r_prev. BAD = anything else (zero, multi-hot, skip, reverse).
//   - pos/pos_valid: pos_valid=ONEHOT; pos loaded with hot index when ONEHOT, else holds old value.
//   - FSM (2-bit): HUNT, VERIFY, LOCKED.
//     HUNT:   ONEHOT -> VERIFY, good_cnt=0; else stay.
//     VERIFY: STEP -> good_cnt++; when good_cnt+1==LOCK_CNT -> LOCKED, good_cnt=0. HOLD -> stay, no
//             increment. BAD -> ONEHOT ? VERIFY with good_cnt=0 : HUNT. No error reported here.
//     LOCKED: STEP -> stay, hold_cnt=0. HOLD -> hold_cnt++; when hold_cnt+1>STALL_MAX -> stall=1,
//             err_count++, -> HUNT. BAD -> err_pulse=1, err_count++, -> ONEHOT ? VERIFY : HUNT.
//   - locked=1 exactly while FSM==LOCKED (registered, same edge as state).
//   - err_count saturates at 2**ERR_W-1; never wraps. stall and err_pulse are mutually exclusive.
//   - Wrap-around: 1000->0001 is a STEP, not an error. First sample after reset (r_prev=0) is never
//     STEP; checker starts in HUNT so no false error.
//   - Reset asserted mid-operation: immediate return to reset values, err_count included.
// STRUCTURE
//   - Package ring_chk_pkg: state_t enum {HUNT, VERIFY, LOCKED}; function rotl1(); function
//     onehot_index() (priority-free, assumes one-hot); popcount-is-one function.
//   - One sub-module natural: ring_onehot_decode (WIDTH in -> index + is_onehot, combinational).
//   - Top holds input regs, classifier, FSM, hold/good counters, saturating error counter.
// TESTING (WIDTH=4, LOCK_CNT=3, STALL_MAX=8, ERR_W=8)
//   1 reset low 3 clks then high; ring_in=0 -> locked=0, pos_valid=0, err_count=0, no pulses.
//   2 drive 0001,0010,0100,1000,0001 one per clk -> pos 0,1,2,3,0; locked=1 two clks after 1000
//     sampled (third STEP); wrap 1000->0001 gives no err_pulse.
//   3 locked, then drive 0100 after 0001 (skip) -> err_pulse=1 one clk, err_count=1, locked=0, FSM
//     VERIFY; three further legal steps -> locked=1 again.
//   4 locked, hold 0010 for 10 clks -> stall=1 once on 9th hold, err_count+1, locked=0, no err_pulse.
//   5 locked, drive 0110 -> err_pulse=1, pos_valid=0, pos holds last index, FSM HUNT; then 0000 ->
//     no further pulse.
//   6 force 300 BAD events while locked -> err_count=255 saturated; assert reset mid-stream ->
//     all outputs 0 asynchronously before next clk edge.

Source files
------------

// File: rtl/ring_chk_pkg.sv
// Shared types and bit-vector helpers for the ring counter checker.
package ring_chk_pkg;

  // Helpers operate on a fixed-width container; ring widths up to MAX_W are supported.
  localparam int unsigned MAX_W     = 32;
  localparam int unsigned MAX_IDX_W = 5;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Rotate the low w bits of v left by one; the MSB of the w-bit field wraps to bit 0.
  function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int unsigned w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

  // OR together the indices of all set bits; exact only when v is one-hot.
  function automatic logic [MAX_IDX_W-1:0] onehot_index(input logic [MAX_W-1:0] v);
    logic [MAX_IDX_W-1:0] idx;
    logic [MAX_W-1:0]     sh;
    idx = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      sh = v >> i;
      if (sh[0]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    int unsigned      cnt;
    logic [MAX_W-1:0] sh;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      sh  = v >> i;
      cnt = cnt + {31'd0, sh[0]};
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot legality check and hot-bit index for a WIDTH-bit word.
module ring_onehot_decode
  import ring_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx_c,
  output logic             is_onehot_c
);

  // Zero-extend into the package container and decode.
  assign idx_c       = IDX_W'(onehot_index(MAX_W'(vec)));
  assign is_onehot_c = is_onehot(MAX_W'(vec));

endmodule

// File: rtl/ring_counter_checker.sv
// Run-time integrity monitor for a one-hot rotate-left ring counter bus.
module ring_counter_checker
  import ring_chk_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned STALL_MAX = 8,
  parameter int unsigned ERR_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         ring_in,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     pos_valid,
  output logic                     locked,
  output logic                     err_pulse,
  output logic                     stall,
  output logic [ERR_W-1:0]         err_count
);

  localparam int unsigned IDX_W  = $clog2(WIDTH);
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned HOLD_W = $clog2(STALL_MAX + 1);

  logic [WIDTH-1:0]  r_cur_q, r_cur_d;
  logic [WIDTH-1:0]  r_prev_q, r_prev_d;
  state_t            state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]  pos_q, pos_d;
  logic              pos_valid_q, pos_valid_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic              stall_q, stall_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  logic [IDX_W-1:0]  idx_c;
  logic              onehot_c;
  logic [WIDTH-1:0]  rot_prev_c;
  logic              step_c;
  logic              hold_c;
  logic [GOOD_W-1:0] good_inc_c;
  logic              err_inc_c;

  ring_onehot_decode #(.WIDTH(WIDTH)) u_decode (
    .vec         (r_cur_q),
    .idx_c       (idx_c),
    .is_onehot_c (onehot_c)
  );

  // Classify the (previous, current) sample pair.
  assign rot_prev_c = WIDTH'(rotl1(MAX_W'(r_prev_q), WIDTH));
  assign step_c     = onehot_c && (r_cur_q == rot_prev_c);
  assign hold_c     = onehot_c && (r_cur_q == r_prev_q);
  assign good_inc_c = good_cnt_q + GOOD_W'(1);

  // Next-state: input pipeline, position tracking, lock FSM and error accounting.
  always_comb begin
    r_cur_d     = ring_in;
    r_prev_d    = r_cur_q;
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    pos_d       = pos_q;
    pos_valid_d = onehot_c;
    err_pulse_d = 1'b0;
    stall_d     = 1'b0;
    err_count_d = err_count_q;
    err_inc_c   = 1'b0;

    if (onehot_c) pos_d = idx_c;

    case (state_q)
      HUNT: begin
        hold_cnt_d = '0;
        if (onehot_c) begin
          state_d    = VERIFY;
          good_cnt_d = '0;
        end
      end
      VERIFY: begin
        hold_cnt_d = '0;
        if (step_c) begin
          if (good_inc_c == GOOD_W'(LOCK_CNT)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_inc_c;
          end
        end else if (!hold_c) begin
          state_d    = onehot_c ? VERIFY : HUNT;
          good_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (step_c) begin
          hold_cnt_d = '0;
        end else if (hold_c) begin
          // Stall fires on the hold that would push the count past STALL_MAX.
          if (hold_cnt_q >= HOLD_W'(STALL_MAX)) begin
            stall_d    = 1'b1;
            err_inc_c  = 1'b1;
            state_d    = HUNT;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end else begin
          err_pulse_d = 1'b1;
          err_inc_c   = 1'b1;
          state_d     = onehot_c ? VERIFY : HUNT;
          good_cnt_d  = '0;
          hold_cnt_d  = '0;
        end
      end
      default: begin
        state_d    = HUNT;
        good_cnt_d = '0;
        hold_cnt_d = '0;
      end
    endcase

    if (err_inc_c && (err_count_q != {ERR_W{1'b1}})) err_count_d = err_count_q + ERR_W'(1);

    locked_d = (state_d == LOCKED);
  end

  // State and output registers with immediate clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_q     <= '0;
      r_prev_q    <= '0;
      state_q     <= HUNT;
      good_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      stall_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      r_cur_q     <= r_cur_d;
      r_prev_q    <= r_prev_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      stall_q     <= stall_d;
      err_count_q <= err_count_d;
    end
  end

  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign stall     = stall_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ring_counter_checker.sv
// Scoreboard bench for ring_counter_checker (WIDTH=4, LOCK_CNT=3, STALL_MAX=8, ERR_W=8).
module tb_ring_counter_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ring_in;
  logic [1:0] pos;
  logic       pos_valid;
  logic       locked;
  logic       err_pulse;
  logic       stall;
  logic [7:0] err_count;

  typedef struct {
    int         due;
    int         tag;
    logic [1:0] pos;
    logic       pv;
    logic       lk;
    logic       ep;
    logic       st;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   tag   = 0;
  int   total = 0;
  int   bad   = 0;

  ring_counter_checker #(
    .WIDTH(4), .LOCK_CNT(3), .STALL_MAX(8), .ERR_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ring_in   (ring_in),
    .pos       (pos),
    .pos_valid (pos_valid),
    .locked    (locked),
    .err_pulse (err_pulse),
    .stall     (stall),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input int p, input bit pv, input bit lk, input bit ep,
                              input bit st, input int ec);
    exp_t e;
    e.due = 0;
    e.tag = 0;
    e.pos = 2'(p);
    e.pv  = pv;
    e.lk  = lk;
    e.ep  = ep;
    e.st  = st;
    e.ec  = 8'(ec);
    return e;
  endfunction

  // Drive one sample on the falling edge and queue the outputs due two rising edges later.
  task automatic drive(input logic [3:0] v, input exp_t e);
    @(negedge clk);
    ring_in = v;
    tag     = tag + 1;
    e.due   = cyc + 2;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string name);
    total = total + 1;
    if ({pos, pos_valid, locked, err_pulse, stall, err_count} !== 14'd0) begin
      bad = bad + 1;
      $display("FAIL %s: got pos=%0d pv=%0b lk=%0b ep=%0b st=%0b ec=%0d, want all zero",
               name, pos, pos_valid, locked, err_pulse, stall, err_count);
    end
  endtask

  // Monitor: pops expectations as their output cycle arrives and compares.
  always @(negedge clk) begin
    total = total + 1;
    if (err_pulse && stall) begin
      bad = bad + 1;
      $display("FAIL excl: got err_pulse=1 stall=1, want at most one set (cyc %0d)", cyc);
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      total = total + 1;
      if (mon_e.due != cyc) begin
        bad = bad + 1;
        $display("FAIL stale#%0d: got check at cyc %0d, want cyc %0d", mon_e.tag, cyc, mon_e.due);
      end else if ({pos, pos_valid, locked, err_pulse, stall, err_count} !==
                   {mon_e.pos, mon_e.pv, mon_e.lk, mon_e.ep, mon_e.st, mon_e.ec}) begin
        bad = bad + 1;
        $display("FAIL sample#%0d: got pos=%0d pv=%0b lk=%0b ep=%0b st=%0b ec=%0d, want pos=%0d pv=%0b lk=%0b ep=%0b st=%0b ec=%0d",
                 mon_e.tag, pos, pos_valid, locked, err_pulse, stall, err_count,
                 mon_e.pos, mon_e.pv, mon_e.lk, mon_e.ep, mon_e.st, mon_e.ec);
      end
    end
  end

  initial begin
    int p;
    int ec;
    logic [3:0] v;

    // 1: reset held low, idle bus
    ring_in = 4'b0000;
    reset   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_values");
    reset = 1'b1;
    drive(4'b0000, mk(0, 0, 0, 0, 0, 0));
    drive(4'b0000, mk(0, 0, 0, 0, 0, 0));

    // 2: acquire lock and wrap 1000->0001
    drive(4'b0001, mk(0, 1, 0, 0, 0, 0));
    drive(4'b0010, mk(1, 1, 0, 0, 0, 0));
    drive(4'b0100, mk(2, 1, 0, 0, 0, 0));
    drive(4'b1000, mk(3, 1, 1, 0, 0, 0));
    drive(4'b0001, mk(0, 1, 1, 0, 0, 0));

    // 3: skip while locked, then relock after three steps
    drive(4'b0100, mk(2, 1, 0, 1, 0, 1));
    drive(4'b1000, mk(3, 1, 0, 0, 0, 1));
    drive(4'b0001, mk(0, 1, 0, 0, 0, 1));
    drive(4'b0010, mk(1, 1, 1, 0, 0, 1));

    // 4: step around to 0010, then hold it for ten samples in total
    drive(4'b0100, mk(2, 1, 1, 0, 0, 1));
    drive(4'b1000, mk(3, 1, 1, 0, 0, 1));
    drive(4'b0001, mk(0, 1, 1, 0, 0, 1));
    drive(4'b0010, mk(1, 1, 1, 0, 0, 1));
    for (int h = 1; h <= 8; h++) drive(4'b0010, mk(1, 1, 1, 0, 0, 1));
    drive(4'b0010, mk(1, 1, 0, 0, 1, 2));
    drive(4'b0010, mk(1, 1, 0, 0, 0, 2));

    // 5: relock, then multi-hot and zero words
    drive(4'b0100, mk(2, 1, 0, 0, 0, 2));
    drive(4'b1000, mk(3, 1, 0, 0, 0, 2));
    drive(4'b0001, mk(0, 1, 1, 0, 0, 2));
    drive(4'b0010, mk(1, 1, 1, 0, 0, 2));
    drive(4'b0110, mk(1, 0, 0, 1, 0, 3));
    drive(4'b0000, mk(1, 0, 0, 0, 0, 3));

    // 6: relock, then 300 skip errors each followed by a relock
    drive(4'b0001, mk(0, 1, 0, 0, 0, 3));
    drive(4'b0010, mk(1, 1, 0, 0, 0, 3));
    drive(4'b0100, mk(2, 1, 0, 0, 0, 3));
    drive(4'b1000, mk(3, 1, 1, 0, 0, 3));
    p  = 3;
    ec = 3;
    for (int i = 0; i < 300; i++) begin
      ec = (ec == 255) ? 255 : ec + 1;
      v  = 4'b0001 << ((p + 2) % 4);
      drive(v, mk((p + 2) % 4, 1, 0, 1, 0, ec));
      v  = 4'b0001 << ((p + 3) % 4);
      drive(v, mk((p + 3) % 4, 1, 0, 0, 0, ec));
      v  = 4'b0001 << (p % 4);
      drive(v, mk(p % 4, 1, 0, 0, 0, ec));
      v  = 4'b0001 << ((p + 1) % 4);
      drive(v, mk((p + 1) % 4, 1, 1, 0, 0, ec));
      p  = (p + 5) % 4;
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending checks, want 0", sb.size());
      sb.delete();
    end
    total = total + 1;
    if (err_count !== 8'd255) begin
      bad = bad + 1;
      $display("FAIL saturate: got err_count=%0d, want 255", err_count);
    end

    // Mid-stream reset must clear outputs before the next rising edge.
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    check_zero("reset_held");
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
